// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, counter types and pipeline record for the VGA scanout.
// Anything that must agree with the DMA engine or VRAM model lives here.
package vga_scanout_pkg;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 24;
    localparam int DEF_V_ACTIVE = 240;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 15;
    localparam int DEF_GUARD    = 2;

    localparam int CNT_W = 10;

    // Pixel byte layout RRRGGGBB
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_LSB = 0;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       hsync_b;
        logic       vsync_b;
        logic       vblank;
    } vid_t;

    localparam vid_t VID_IDLE = '{pix: 8'h00, hsync_b: 1'b1, vsync_b: 1'b1, vblank: 1'b0};

    function automatic logic in_window(input cnt_t x, input int lo, input int len);
        return (x >= cnt_t'(lo)) && (x < cnt_t'(lo + len));
    endfunction

endpackage

// File: rtl/vga_hv_counter.sv
// Free-running raster position counters with line-end and next-line-active flags.
// Counters are registered; all flags are combinational from them.
module vga_hv_counter
    import vga_scanout_pkg::*;
#(
    parameter int H_TOTAL  = 320,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240
) (
    input  logic clk_i,
    input  logic rst_i,
    output cnt_t h_o,
    output cnt_t v_o,
    output logic line_end_o,
    output logic frame_end_o,
    output logic next_active_o
);

    cnt_t h_q, h_d;
    cnt_t v_q, v_d;

    assign line_end_o  = (h_q == cnt_t'(H_TOTAL - 1));
    assign frame_end_o = line_end_o && (v_q == cnt_t'(V_TOTAL - 1));
    // Last frame line counts as "next active" so the guard band precedes line 0.
    assign next_active_o = ((v_q + cnt_t'(1)) < cnt_t'(V_ACTIVE)) ||
                           (v_q == cnt_t'(V_TOTAL - 1));

    always_comb begin
        h_d = h_q + cnt_t'(1);
        v_d = v_q;
        if (line_end_o) begin
            h_d = '0;
            v_d = frame_end_o ? '0 : v_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA timing + VRAM fetch; pixel/sync/irq outputs 2 cycles behind the raster counters.
// Bus handed to the DMA in blanking, reclaimed a guard band before each active line.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int GUARD    = DEF_GUARD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_vram_addr,
    output logic        o_vram_oe_b,
    input  logic [7:0]  i_vram_data,
    output logic        o_free_vbus_b,
    output logic        o_hsync_b,
    output logic        o_vsync_b,
    output logic [7:0]  o_rgb,
    output logic        o_vblank_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_ACTIVE > 256) || (V_ACTIVE > 256)) begin : g_cfg_err
        $error("vga_scanout: active area must fit the 8-bit x/y address fields");
    end

    cnt_t h, v;
    logic line_end, frame_end, next_active;

    vga_hv_counter #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .V_ACTIVE (V_ACTIVE)
    ) u_hv (
        .clk_i         (i_clk),
        .rst_i         (i_rst),
        .h_o           (h),
        .v_o           (v),
        .line_end_o    (line_end),
        .frame_end_o   (frame_end),
        .next_active_o (next_active)
    );

    logic        fetch, own;
    logic [15:0] addr;

    assign fetch = !i_rst && (h < cnt_t'(H_ACTIVE)) && (v < cnt_t'(V_ACTIVE));
    // h==H_ACTIVE keeps the bus for the cycle the last read is still in flight.
    assign own = i_rst || fetch ||
                 ((h == cnt_t'(H_ACTIVE)) && (v < cnt_t'(V_ACTIVE))) ||
                 ((h >= cnt_t'(H_TOTAL - GUARD)) && next_active && !frame_end) ||
                 (frame_end);
    assign addr = fetch ? {v[7:0], h[7:0]} : 16'h0000;

    assign o_free_vbus_b = own;
    assign o_vram_addr   = own ? addr : 16'hzzzz;
    assign o_vram_oe_b   = own ? !fetch : 1'bz;

    vid_t s1_d, s1_q, s2_q;
    logic vbl_q, vbl_d;

    // Vertical-blank start is decoded one cycle early so it registers in step with h=0.
    assign vbl_d = line_end && (v == cnt_t'(V_ACTIVE - 1));

    always_comb begin
        s1_d         = VID_IDLE;
        s1_d.pix     = fetch ? i_vram_data : 8'h00;
        s1_d.hsync_b = !in_window(h, H_ACTIVE + H_FP, H_SYNC);
        s1_d.vsync_b = !in_window(v, V_ACTIVE + V_FP, V_SYNC);
        s1_d.vblank  = vbl_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vbl_q <= 1'b0;
            s1_q  <= VID_IDLE;
            s2_q  <= VID_IDLE;
        end else begin
            vbl_q <= vbl_d;
            s1_q  <= s1_d;
            s2_q  <= s1_q;
        end
    end

    assign o_rgb        = s2_q.pix;
    assign o_hsync_b    = s2_q.hsync_b;
    assign o_vsync_b    = s2_q.vsync_b;
    assign o_vblank_irq = s2_q.vblank;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboarded check of raster timing, bus ownership and pixel pipeline of vga_scanout.
`timescale 1ns/1ps
module tb_vga_scanout;

    localparam int HT = 320;
    localparam int VT = 262;
    localparam int HA = 256;
    localparam int VA = 240;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] vram_addr;
    wire         vram_oe_b;
    logic [7:0]  vram_data;
    logic        free_b, hs_b, vs_b, irq;
    logic [7:0]  rgb;

    always #5 clk = ~clk;

    // VRAM content: byte at {y,x} is x+y, so both address halves matter.
    assign vram_data = vram_addr[7:0] + vram_addr[15:8];

    vga_scanout dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_vram_addr   (vram_addr),
        .o_vram_oe_b   (vram_oe_b),
        .i_vram_data   (vram_data),
        .o_free_vbus_b (free_b),
        .o_hsync_b     (hs_b),
        .o_vsync_b     (vs_b),
        .o_rgb         (rgb),
        .o_vblank_irq  (irq)
    );

    typedef struct packed {
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       irq;
    } dly_t;

    typedef struct {
        int          h;
        int          v;
        logic        free;
        logic        oe;
        logic [15:0] addr;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        irq;
    } vec_t;

    dly_t  q[$];
    int    mh, mv, cyc;
    int    n_checks = 0;
    int    n_pass = 0;
    bit    line_bad;
    int    line_samples;
    string line_msg;
    int    irq_cyc, vs_fall_cyc;
    logic  vs_prev;
    vec_t  vecs[18];

    task automatic check(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic bit exp_fetch(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic bit exp_own(input int h, input int v);
        return exp_fetch(h, v) || ((h == HA) && (v < VA)) ||
               ((h >= HT - 2) && ((v + 1 < VA) || (v == VT - 1)));
    endfunction

    function automatic dly_t idle_dly();
        dly_t d;
        d.rgb = 8'h00; d.hs = 1'b1; d.vs = 1'b1; d.irq = 1'b0;
        return d;
    endfunction

    task automatic end_line();
        if (line_samples > 0)
            check(!line_bad, $sformatf("line%0d", mv), line_msg);
        line_bad = 1'b0;
        line_samples = 0;
        line_msg = "";
    endtask

    task automatic mon();
        bit          f, o, bad;
        logic [15:0] ea;
        dly_t        e, d;
        f  = exp_fetch(mh, mv);
        o  = exp_own(mh, mv);
        ea = f ? {mv[7:0], mh[7:0]} : 16'h0000;
        e.rgb = f ? (ea[7:0] + ea[15:8]) : 8'h00;
        e.hs  = !((mh >= HA + 8) && (mh < HA + 8 + 32));
        e.vs  = !((mv >= VA + 3) && (mv < VA + 3 + 4));
        e.irq = (mh == 0) && (mv == VA);
        q.push_back(e);
        d = q.pop_front();
        bad = (free_b !== o) ||
              (o && ((vram_oe_b !== !f) || (vram_addr !== ea))) ||
              (rgb !== d.rgb) || (hs_b !== d.hs) || (vs_b !== d.vs) || (irq !== d.irq);
        if (bad && !line_bad) begin
            line_bad = 1'b1;
            line_msg = $sformatf("h=%0d got free=%b oe=%b addr=%h rgb=%h hs=%b vs=%b irq=%b want free=%b oe=%b addr=%h rgb=%h hs=%b vs=%b irq=%b",
                                 mh, free_b, vram_oe_b, vram_addr, rgb, hs_b, vs_b, irq,
                                 o, !f, ea, d.rgb, d.hs, d.vs, d.irq);
        end
        line_samples++;
        if (irq && irq_cyc < 0) irq_cyc = cyc;
        if (vs_prev && !vs_b && vs_fall_cyc < 0) vs_fall_cyc = cyc;
        vs_prev = vs_b;
        if (mh == HT - 1) end_line();
    endtask

    task automatic model_adv();
        cyc++;
        if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic cycle_end();
        mon();
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_model();
        mh = 0; mv = 0; cyc = 0;
        q.delete();
        q.push_back(idle_dly());
        q.push_back(idle_dly());
        irq_cyc = -1; vs_fall_cyc = -1; vs_prev = 1'b1;
        line_bad = 1'b0; line_samples = 0; line_msg = "";
    endtask

    task automatic wait_to(input int h, input int v);
        int g = 0;
        while (!(mh == h && mv == v) && g < 90000) begin
            @(negedge clk);
            cycle_end();
            g++;
        end
        if (!(mh == h && mv == v))
            check(1'b0, "wait", $sformatf("reached (%0d,%0d) want (%0d,%0d)", mh, mv, h, v));
    endtask

    task automatic apply_vec(input vec_t t);
        bit ok;
        wait_to(t.h, t.v);
        @(negedge clk);
        ok = (free_b === t.free) &&
             (!t.free || ((vram_oe_b === t.oe) && (vram_addr === t.addr))) &&
             (rgb === t.rgb) && (hs_b === t.hs) && (vs_b === t.vs) && (irq === t.irq);
        check(ok, $sformatf("vec(%0d,%0d)", t.h, t.v),
              $sformatf("got free=%b oe=%b addr=%h rgb=%h hs=%b vs=%b irq=%b want free=%b oe=%b addr=%h rgb=%h hs=%b vs=%b irq=%b",
                        free_b, vram_oe_b, vram_addr, rgb, hs_b, vs_b, irq,
                        t.free, t.oe, t.addr, t.rgb, t.hs, t.vs, t.irq));
        cycle_end();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // (h, v, free, oe_b, addr, rgb, hsync_b, vsync_b, irq) seen while counters are at (h,v)
        vecs[0]  = '{2,   0,   1'b1, 1'b0, 16'h0002, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{100, 5,   1'b1, 1'b0, 16'h0564, 8'h67, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{256, 10,  1'b1, 1'b1, 16'h0000, 8'h08, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{257, 10,  1'b0, 1'b1, 16'h0000, 8'h09, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{258, 10,  1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{266, 10,  1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{297, 10,  1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{298, 10,  1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{318, 10,  1'b1, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{255, 239, 1'b1, 1'b0, 16'hEFFF, 8'hEC, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{318, 239, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{2,   240, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{3,   240, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1,   243, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{2,   243, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{5,   246, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{2,   247, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{318, 261, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        restart_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(free_b === 1'b1, "rst_free", $sformatf("got %b want 1", free_b));
        check(vram_oe_b === 1'b1, "rst_oe", $sformatf("got %b want 1", vram_oe_b));
        check(vram_addr === 16'h0000, "rst_addr", $sformatf("got %h want 0000", vram_addr));
        check(rgb === 8'h00, "rst_rgb", $sformatf("got %h want 00", rgb));
        check(hs_b === 1'b1 && vs_b === 1'b1, "rst_sync", $sformatf("got hs=%b vs=%b want 1 1", hs_b, vs_b));
        check(irq === 1'b0, "rst_irq", $sformatf("got %b want 0", irq));
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart_model();

        // Run into a line, then abandon it with a one-cycle reset.
        wait_to(50, 3);
        end_line();
        rst = 1'b1;
        @(negedge clk);
        check(free_b === 1'b1 && vram_oe_b === 1'b1 && vram_addr === 16'h0000, "pulse_bus",
              $sformatf("got free=%b oe=%b addr=%h want 1 1 0000", free_b, vram_oe_b, vram_addr));
        @(posedge clk);
        #1;
        rst = 1'b0;
        restart_model();
        @(negedge clk);
        check(free_b === 1'b1 && vram_oe_b === 1'b0 && vram_addr === 16'h0000, "pulse_first_fetch",
              $sformatf("got free=%b oe=%b addr=%h want 1 0 0000", free_b, vram_oe_b, vram_addr));
        check(rgb === 8'h00 && hs_b === 1'b1 && vs_b === 1'b1 && irq === 1'b0, "pulse_pipe_clear",
              $sformatf("got rgb=%h hs=%b vs=%b irq=%b want 00 1 1 0", rgb, hs_b, vs_b, irq));
        cycle_end();

        for (int i = 0; i < 18; i++) apply_vec(vecs[i]);

        // Frame wrap: the bus must stay owned from the guard band straight into fetch (0,0).
        @(negedge clk);
        check(free_b === 1'b1, "wrap_319", $sformatf("got free=%b want 1", free_b));
        cycle_end();
        @(negedge clk);
        check(free_b === 1'b1 && vram_oe_b === 1'b0 && vram_addr === 16'h0000, "wrap_fetch00",
              $sformatf("got free=%b oe=%b addr=%h want 1 0 0000", free_b, vram_oe_b, vram_addr));
        cycle_end();

        check(irq_cyc == 240 * 320 + 2, "irq_latency", $sformatf("got %0d want %0d", irq_cyc, 240 * 320 + 2));
        check(vs_fall_cyc == 243 * 320 + 2, "vsync_start", $sformatf("got %0d want %0d", vs_fall_cyc, 243 * 320 + 2));
        end_line();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
